hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
- REQ-001 SHALL take parameter REG_AW, default 4: register-address width; NUM_REGS = 2**REG_AW.
- REQ-002 SHALL take parameter NUM_SRC, default 2, legal range 1..4: number of source operands checked per decode instruction.
- REQ-003 SHALL take parameter LOAD_LAT, default 2, legal range 1..7: cycles after a load leaves Exe before its result can be forwarded.
- REQ-004 SHALL take parameter CNT_W, default 16: width of the stall statistics counter.
- REQ-005 clk  in  1  single clock for all state; all flops rising-edge.
- REQ-006 rst_n  in  1  reset, asynchronous, active-low.
- REQ-007 src_addr  in  NUM_SRC*REG_AW  decode-stage source addresses; operand i is bits [i*REG_AW +: REG_AW].
- REQ-008 src_re  in  NUM_SRC  per-operand read enable.
- REQ-009 dec_valid  in  1  decode holds a valid instruction.
- REQ-010 flush  in  1  decode instruction is being squashed this cycle.
- REQ-011 ld_issue  in  1  a memory-read instruction occupies Exe this cycle.
- REQ-012 ld_dst  in  REG_AW  destination register of that load.
- REQ-013 mem_busy  in  1  data memory not ready; pipeline frozen this cycle.
- REQ-014 nop_mux  out  1  inject a NOP into Exe.
- REQ-015 f_reg_hold  out  1  hold the fetch/decode register.
- REQ-016 pc_hold  out  1  hold the PC.
- REQ-017 pending  out  NUM_REGS  bit r is high when register r has a load in flight (cnt[r]!=0).
- REQ-018 stall_cnt  out  CNT_W  number of hazard stall cycles since reset.

Function
- REQ-019 SHALL keep one countdown cnt[r] of width clog2(LOAD_LAT+1) per register.
- REQ-020 On ld_issue=1 and mem_busy=0, cnt[ld_dst] SHALL load LOAD_LAT at the next edge, overriding any decrement or prior value for that register.
- REQ-021 Every other nonzero cnt[r] SHALL decrement by 1 per cycle when mem_busy=0; zero SHALL stay at zero (no wrap).
- REQ-022 With mem_busy=1, all cnt[r] SHALL hold and ld_issue SHALL be ignored.
- REQ-023 Operand i SHALL be hazardous when src_re[i]=1 and either cnt[src_addr_i]!=0, or ld_issue=1 and src_addr_i==ld_dst (same-cycle load-use).
- REQ-024 hazard SHALL be the OR over all operands; register 0 is an ordinary register.
- REQ-025 stall SHALL be hazard AND dec_valid AND NOT flush, and SHALL be combinational (zero latency).
- REQ-026 f_reg_hold = pc_hold = stall.
- REQ-027 nop_mux = stall OR flush.
- REQ-028 A stalled instruction SHALL re-evaluate every cycle and release the first cycle all its operands are clear.
- REQ-029 flush SHALL NOT modify cnt[]: loads already in Exe still complete.
- REQ-030 stall_cnt SHALL increment on each cycle with stall=1 and mem_busy=0, and SHALL saturate at all-ones.

Reset
- REQ-031 rst_n=0 SHALL asynchronously clear all cnt[] and stall_cnt to 0.
- REQ-032 During reset, pending=0, and nop_mux, f_reg_hold and pc_hold SHALL follow REQ-025..027 with an empty scoreboard.
- REQ-033 Reset asserted mid-countdown SHALL discard all in-flight loads; after release no stall SHALL arise from them.

Structure
- REQ-034 A shared package SHALL hold default REG_AW, LOAD_LAT, CNT_W and a clog2 constant function.
- REQ-035 The per-register countdown SHALL be a sub-module hazard_sb_entry (inputs: load, freeze; output: busy), instantiated NUM_REGS times with generate.
- REQ-036 Operand comparators SHALL be generated per NUM_SRC.

Verification (defaults)
- REQ-037 ld_issue=1, ld_dst=5; same cycle src_addr0=5, src_re=01, dec_valid=1 -> stall=1 that cycle and the next 2, stall=0 on the 4th; stall_cnt=3.
- REQ-038 ld_issue with ld_dst=3, then mem_busy=1 for 4 cycles -> pending[3] stays 1 across the freeze; the stall covers LOAD_LAT non-busy cycles only.
- REQ-039 Load to r7, then another load to r7 one cycle later -> cnt[7] reloads to 2; stall lasts 3 cycles total after the second load.
- REQ-040 Hazard on r2 with flush=1 -> stall=0, nop_mux=1, and pending[2] is unchanged.
- REQ-041 Loads to r1 and r9 in flight, rst_n pulsed low mid-count -> pending=0 immediately, stall_cnt=0, and no stall after release.
- REQ-042 src_re=00 with matching addresses -> stall=0; stall_cnt forced near all-ones, then 3 stall cycles -> stall_cnt holds at all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and helpers for the load-use hazard scoreboard.
//   DEF_REG_AW   : default register-address width
//   DEF_LOAD_LAT : default load-to-forward latency in cycles
//   DEF_CNT_W    : default stall statistics counter width
//   clog2()      : ceiling log2, used to size the per-register countdown
package hazard_scoreboard_pkg;

  localparam int unsigned DEF_REG_AW   = 4;
  localparam int unsigned DEF_LOAD_LAT = 2;
  localparam int unsigned DEF_CNT_W    = 16;

  // Smallest r with 2**r >= v (returns 0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown of cycles until a load result is forwardable.
//   clk, rst_n : clock, async active-low reset
//   load       : a load targeting this register leaves Exe this cycle
//   freeze     : pipeline frozen; hold the count and ignore load
//   busy       : count is nonzero (load still in flight)
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic freeze,
  output logic busy
);

  localparam int unsigned CW = clog2(LOAD_LAT + 1);

  logic [CW-1:0] r_cnt;

  // A new load overrides the running count; zero never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        r_cnt <= CW'(LOAD_LAT);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector for a decode stage.
//   clk, rst_n         : clock, async active-low reset
//   src_addr, src_re   : decode source operands and their read enables
//   dec_valid, flush   : decode has a valid instruction / it is being squashed
//   ld_issue, ld_dst   : load in Exe this cycle and its destination register
//   mem_busy           : pipeline frozen; scoreboard and statistics hold
//   nop_mux            : inject NOP into Exe (combinational)
//   f_reg_hold, pc_hold: hold fetch/decode register and PC (combinational)
//   pending            : per-register load-in-flight flags
//   stall_cnt          : saturating count of hazard stall cycles
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW   = DEF_REG_AW,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_re,
  input  logic                      dec_valid,
  input  logic                      flush,
  input  logic                      ld_issue,
  input  logic [REG_AW-1:0]         ld_dst,
  input  logic                      mem_busy,
  output logic                      nop_mux,
  output logic                      f_reg_hold,
  output logic                      pc_hold,
  output logic [(2**REG_AW)-1:0]    pending,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_SRC-1:0]  w_op_haz;
  logic                w_stall;
  logic [CNT_W-1:0]    r_stall_cnt;

  // Per-register countdowns; mem_busy freezes every entry.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    logic w_load;
    assign w_load = ld_issue && (ld_dst == REG_AW'(r));

    hazard_sb_entry #(
      .LOAD_LAT (LOAD_LAT)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_load),
      .freeze (mem_busy),
      .busy   (w_busy[r])
    );
  end

  // Operand hazard: load in flight, or load-use against the load now in Exe.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] w_addr;
    assign w_addr      = src_addr[i*REG_AW +: REG_AW];
    assign w_op_haz[i] = src_re[i] && (w_busy[w_addr] || (ld_issue && (w_addr == ld_dst)));
  end

  assign w_stall    = (|w_op_haz) && dec_valid && !flush;
  assign f_reg_hold = w_stall;
  assign pc_hold    = w_stall;
  assign nop_mux    = w_stall || flush;
  assign pending    = w_busy;

  // Stall statistics: frozen cycles are not counted; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !mem_busy && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
